// File: rtl/obstacle_scan_logic_if.sv
// Bundle between the game engine and its producers/consumers.
// master: pipe/bird/control side; slave: obstacle_scan_logic.
interface obstacle_scan_logic_if #(
  parameter int NUM_PIPES = 4,
  parameter int COORD_W   = 10,
  parameter int SCORE_W   = 4
);
  localparam int IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  logic                          Start;
  logic                          Ack;
  logic                          Tick;
  logic [COORD_W-1:0]            Bird_X;
  logic [COORD_W-1:0]            Bird_Y;
  logic [NUM_PIPES*COORD_W-1:0]  Pipe_X;
  logic [NUM_PIPES*COORD_W-1:0]  Pipe_Gap_Y;
  logic                          Q_Initial;
  logic                          Q_Check;
  logic                          Q_Lose;
  logic                          Busy;
  logic [SCORE_W-1:0]            Score;
  logic [SCORE_W-1:0]            Best_Score;
  logic                          Score_Inc;
  logic [IDX_W-1:0]              Hit_Pipe;
  logic                          Hit_Floor;

  modport master (
    output Start, Ack, Tick, Bird_X, Bird_Y, Pipe_X, Pipe_Gap_Y,
    input  Q_Initial, Q_Check, Q_Lose, Busy, Score, Best_Score,
    input  Score_Inc, Hit_Pipe, Hit_Floor
  );

  modport slave (
    input  Start, Ack, Tick, Bird_X, Bird_Y, Pipe_X, Pipe_Gap_Y,
    output Q_Initial, Q_Check, Q_Lose, Busy, Score, Best_Score,
    output Score_Inc, Hit_Pipe, Hit_Floor
  );
endinterface

// File: rtl/obstacle_scan_logic.sv
// Flappy game-state, collision and scoring engine; scans one pipe per clock.
// Ports: Clk, reset (async, high), bus (slave: controls, coords, state/score).
module obstacle_scan_logic #(
  parameter int NUM_PIPES = 4,
  parameter int COORD_W   = 10,
  parameter int PIPE_W    = 80,
  parameter int GAP_H     = 100,
  parameter int BIRD_W    = 16,
  parameter int BIRD_H    = 16,
  parameter int SCREEN_H  = 480,
  parameter int SCORE_W   = 4
) (
  input  logic                  Clk,
  input  logic                  reset,
  obstacle_scan_logic_if.slave  bus
);

  localparam int IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam int CW1   = COORD_W + 1;

  typedef enum logic [1:0] {
    QINITIAL = 2'd0,
    QCHECK   = 2'd1,
    QLOSE    = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                 busy;
  logic [IDX_W-1:0]     idx;
  logic [COORD_W-1:0]   bx_s;
  logic [COORD_W-1:0]   by_s;
  logic [NUM_PIPES-1:0] passed;
  logic [SCORE_W-1:0]   score;
  logic [SCORE_W-1:0]   best;
  logic                 score_inc;
  logic [IDX_W-1:0]     hit_pipe;
  logic                 hit_floor;

  logic [COORD_W-1:0] px_a [NUM_PIPES];
  logic [COORD_W-1:0] gy_a [NUM_PIPES];

  always_comb begin
    for (int k = 0; k < NUM_PIPES; k++) begin
      px_a[k] = bus.Pipe_X[k*COORD_W +: COORD_W];
      gy_a[k] = bus.Pipe_Gap_Y[k*COORD_W +: COORD_W];
    end
  end

  // All geometry at one extra bit so edge sums never wrap.
  logic [CW1-1:0] px, gy, bx, by;
  logic xov, out_gap, hit, pass, floor_hit;
  logic tick_go, scan_hit, last, lose_entry;

  assign px = {1'b0, px_a[idx]};
  assign gy = {1'b0, gy_a[idx]};
  assign bx = {1'b0, bx_s};
  assign by = {1'b0, by_s};

  assign xov = (bx + CW1'(BIRD_W) > px) &&
               (bx < px + CW1'(PIPE_W));
  assign out_gap = (by < gy) ||
                   (by + CW1'(BIRD_H) > gy + CW1'(GAP_H));
  assign hit  = xov && out_gap;
  assign pass = (px + CW1'(PIPE_W) <= bx);

  // Floor uses the live bird position on the Tick cycle.
  assign floor_hit = ({1'b0, bus.Bird_Y} + CW1'(BIRD_H))
                     >= CW1'(SCREEN_H);

  assign tick_go  = (state == QCHECK) && bus.Tick && !busy;
  assign scan_hit = (state == QCHECK) && busy && hit;
  assign last     = (idx == IDX_W'(NUM_PIPES - 1));

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state <= QINITIAL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      QINITIAL: if (bus.Start) state_nxt = QCHECK;
      QCHECK: begin
        if (tick_go && floor_hit) state_nxt = QLOSE;
        else if (scan_hit)        state_nxt = QLOSE;
      end
      QLOSE:    if (bus.Ack) state_nxt = QINITIAL;
      default:  state_nxt = QINITIAL;
    endcase
  end

  logic q_init, q_check, q_lose;

  always_comb begin
    q_init  = 1'b0;
    q_check = 1'b0;
    q_lose  = 1'b0;
    case (state)
      QINITIAL: q_init  = 1'b1;
      QCHECK:   q_check = 1'b1;
      QLOSE:    q_lose  = 1'b1;
      default:  q_init  = 1'b0;
    endcase
  end

  assign lose_entry = (state == QCHECK) && (state_nxt == QLOSE);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      idx       <= '0;
      bx_s      <= '0;
      by_s      <= '0;
      passed    <= '0;
      score     <= '0;
      best      <= '0;
      score_inc <= 1'b0;
      hit_pipe  <= '0;
      hit_floor <= 1'b0;
    end else begin
      score_inc <= 1'b0;
      if (state == QINITIAL && bus.Start) begin
        score     <= '0;
        passed    <= '0;
        hit_pipe  <= '0;
        hit_floor <= 1'b0;
      end
      if (state != QCHECK) begin
        busy <= 1'b0;
      end else if (tick_go) begin
        if (floor_hit) begin
          hit_floor <= 1'b1;
        end else begin
          busy <= 1'b1;
          idx  <= '0;
          bx_s <= bus.Bird_X;
          by_s <= bus.Bird_Y;
        end
      end else if (busy) begin
        if (hit) begin
          hit_pipe <= idx;
          busy     <= 1'b0;
        end else begin
          // A pipe that is no longer passed has been recycled right.
          if (pass) begin
            if (!passed[idx]) begin
              passed[idx] <= 1'b1;
              score_inc   <= 1'b1;
              if (score != '1) score <= score + 1'b1;
            end
          end else begin
            passed[idx] <= 1'b0;
          end
          if (last) busy <= 1'b0;
          else      idx  <= idx + 1'b1;
        end
      end
      if (lose_entry && score > best) best <= score;
    end
  end

  assign bus.Q_Initial  = q_init;
  assign bus.Q_Check    = q_check;
  assign bus.Q_Lose     = q_lose;
  assign bus.Busy       = busy;
  assign bus.Score      = score;
  assign bus.Best_Score = best;
  assign bus.Score_Inc  = score_inc;
  assign bus.Hit_Pipe   = hit_pipe;
  assign bus.Hit_Floor  = hit_floor;

endmodule
